// File: rtl/leaf_dispatch_pkg.sv
// Shared types and default sizing for the leaf job dispatcher.
package leaf_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } leaf_state_e;

    localparam int N_LEAF_DEF    = 5;
    localparam int JOB_W_DEF     = 16;
    localparam int CPL_DEPTH_DEF = 4;

    // Index width for n entries, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/leaf_job_dispatcher_if.sv
// Upstream job handshake and downstream completion handshake of the dispatcher.
interface leaf_job_dispatcher_if #(
    parameter int JOB_W = leaf_dispatch_pkg::JOB_W_DEF,
    parameter int ID_W  = leaf_dispatch_pkg::id_width(leaf_dispatch_pkg::N_LEAF_DEF)
);
    logic             job_valid;
    logic             job_ready;
    logic [JOB_W-1:0] job_data;
    logic             cpl_valid;
    logic             cpl_ready;
    logic [ID_W-1:0]  cpl_leaf;

    modport master (
        output job_valid, job_data, cpl_ready,
        input  job_ready, cpl_valid, cpl_leaf
    );

    modport slave (
        input  job_valid, job_data, cpl_ready,
        output job_ready, cpl_valid, cpl_leaf
    );
endinterface

// File: rtl/leaf_cpl_fifo.sv
// Completion FIFO holding leaf indices; a push is accepted when full only if a pop
// happens in the same cycle.
module leaf_cpl_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign valid   = (count != '0);
    assign pop     = valid && pop_ready;
    assign push_ok = !full || pop;
    assign do_push = push && push_ok;
    assign data    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide so they wrap at DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/leaf_job_dispatcher.sv
// Round-robin job dispatcher for N_LEAF leaves with per-leaf FSMs and a completion queue.
//   state | meaning
//   IDLE  | leaf free, eligible for dispatch
//   RUN   | job started, waiting for leaf_done
//   PEND  | done seen, waiting to push its completion record
module leaf_job_dispatcher
    import leaf_dispatch_pkg::*;
#(
    parameter int N_LEAF    = N_LEAF_DEF,
    parameter int JOB_W     = JOB_W_DEF,
    parameter int CPL_DEPTH = CPL_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    leaf_job_dispatcher_if.slave bus,
    output logic [N_LEAF-1:0] leaf_start,
    output logic [JOB_W-1:0]  leaf_job,
    input  logic [N_LEAF-1:0] leaf_done,
    output logic [N_LEAF-1:0] busy
);
    localparam int ID_W = id_width(N_LEAF);

    leaf_state_e       state_q [N_LEAF];
    leaf_state_e       state_d [N_LEAF];
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   sel;
    logic [ID_W-1:0]   push_id;
    logic              any_idle;
    logic              pend_any;
    logic              push_ok;
    logic              push;
    logic              accept;

    // First IDLE leaf at or after rr_ptr, searching modulo N_LEAF.
    always_comb begin
        sel      = '0;
        any_idle = 1'b0;
        for (int k = 0; k < N_LEAF; k++) begin
            if (!any_idle && state_q[(int'(rr_ptr) + k) % N_LEAF] == IDLE) begin
                any_idle = 1'b1;
                sel      = ID_W'((int'(rr_ptr) + k) % N_LEAF);
            end
        end
    end

    always_comb begin
        push_id  = '0;
        pend_any = 1'b0;
        for (int i = 0; i < N_LEAF; i++) begin
            if (!pend_any && state_q[i] == PEND) begin
                pend_any = 1'b1;
                push_id  = ID_W'(i);
            end
        end
    end

    assign bus.job_ready = any_idle;
    assign accept        = bus.job_valid && any_idle;
    assign push          = pend_any && push_ok;

    always_comb begin
        for (int i = 0; i < N_LEAF; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (accept && sel == ID_W'(i))     state_d[i] = RUN;
                RUN:     if (leaf_done[i])                  state_d[i] = PEND;
                PEND:    if (push && push_id == ID_W'(i))   state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LEAF; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < N_LEAF; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            leaf_start <= '0;
            leaf_job   <= '0;
        end else begin
            leaf_start <= accept ? (N_LEAF'(1) << sel) : '0;
            if (accept) begin
                leaf_job <= bus.job_data;
                rr_ptr   <= (sel == ID_W'(N_LEAF - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_LEAF; i++) begin
            busy[i] = (state_q[i] != IDLE);
        end
    end

    leaf_cpl_fifo #(
        .WIDTH (ID_W),
        .DEPTH (CPL_DEPTH)
    ) u_cpl_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_id),
        .push_ok   (push_ok),
        .pop_ready (bus.cpl_ready),
        .valid     (bus.cpl_valid),
        .data      (bus.cpl_leaf)
    );
endmodule

// File: doc/leaf_job_dispatcher.md
LEAF_JOB_DISPATCHER -- requirements
Module: leaf_job_dispatcher

Interface
REQ-001 Parameter N_LEAF, default 5: number of leaf instances served.
REQ-002 Parameter JOB_W, default 16: job descriptor width.
REQ-003 Parameter CPL_DEPTH, default 4: completion FIFO depth, power of two, at least 2.
REQ-004 Derived ID_W = $clog2(N_LEAF), minimum 1.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 job_valid  in  1  upstream job offered.
REQ-008 job_ready  out  1  dispatcher can accept a job this cycle.
REQ-009 job_data  in  JOB_W  job descriptor.
REQ-010 leaf_start  out  N_LEAF  one-hot, single-cycle start pulse to the selected leaf.
REQ-011 leaf_job  out  JOB_W  descriptor for the leaf being started; holds its value until the next start.
REQ-012 leaf_done  in  N_LEAF  per-leaf single-cycle completion pulse.
REQ-013 busy  out  N_LEAF  per-leaf "not IDLE" status.
REQ-014 cpl_valid  out  1  completion record available.
REQ-015 cpl_ready  in  1  downstream accepts completion.
REQ-016 cpl_leaf  out  ID_W  index of the completed leaf.

Function
REQ-017 Each leaf SHALL have a 3-state FSM: IDLE -> RUN (on dispatch) -> PEND (on leaf_done) -> IDLE (when its completion is pushed).
REQ-018 job_ready SHALL be combinational: 1 iff at least one leaf is IDLE; it SHALL NOT depend on job_valid.
REQ-019 On accept (job_valid && job_ready) at cycle t, the selected leaf is the first IDLE leaf at or after rr_ptr, searching modulo N_LEAF.
REQ-020 At t+1: leaf_start[sel] SHALL be 1 for exactly one cycle, leaf_job SHALL equal the accepted job_data, and the leaf SHALL be in RUN; rr_ptr SHALL become (sel+1) mod N_LEAF.
REQ-021 A leaf_done[i] pulse while leaf i is in RUN SHALL move leaf i to PEND next cycle; a pulse in IDLE or PEND SHALL be ignored.
REQ-022 Each cycle, if the FIFO can accept a push, the lowest-index PEND leaf SHALL be pushed and return to IDLE next cycle. Only one push per cycle.
REQ-023 The FIFO can accept a push when count < CPL_DEPTH, or when count == CPL_DEPTH and a pop occurs in the same cycle.
REQ-024 cpl_valid SHALL be 1 iff count > 0, and cpl_leaf SHALL be the oldest entry. A pop occurs on cpl_valid && cpl_ready.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; a pop on an empty FIFO SHALL have no effect.
REQ-026 The FIFO read and write pointers SHALL wrap modulo CPL_DEPTH.
REQ-027 With all leaves non-IDLE, job_ready SHALL be 0 and no start is issued.
REQ-028 A leaf freed (PEND -> IDLE) at cycle t SHALL be eligible for dispatch at t+1.

Reset
REQ-029 While rst_n = 0: every leaf SHALL be IDLE, rr_ptr = 0, FIFO count and pointers = 0, leaf_start = 0, leaf_job = 0, busy = 0, cpl_valid = 0, cpl_leaf = 0.
REQ-030 Reset asserted mid-operation SHALL discard all RUN/PEND state and queued completions; leaf_done pulses arriving after reset release for pre-reset jobs SHALL be ignored, per REQ-021.
REQ-031 The first accept SHALL be possible in the first rising edge after rst_n deasserts.

Structure
REQ-032 Package leaf_dispatch_pkg SHALL hold the leaf state enum (IDLE, RUN, PEND) and the default values of N_LEAF, JOB_W and CPL_DEPTH.
REQ-033 The completion FIFO SHALL be a separate sub-module, leaf_cpl_fifo, parameterised by width ID_W and depth CPL_DEPTH; round-robin selection and the leaf FSMs stay in the top module.

Verification
REQ-034 Round-robin: after reset, 5 back-to-back jobs 0xA0..0xA4 with no done -> leaf_start = 0x01, 0x02, 0x04, 0x08, 0x10 on consecutive cycles, then job_ready = 0.
REQ-035 Skip busy leaf: leaves 0-2 in RUN, rr_ptr = 1 -> the next job goes to leaf 3, then leaf 4, and rr_ptr = 0.
REQ-036 Simultaneous done: leaf_done = 0x1F in one cycle with cpl_ready = 1 -> cpl_leaf sequence 0, 1, 2, 3, 4 on consecutive valid cycles.
REQ-037 Backpressure: cpl_ready = 0, all 5 leaves done -> 4 entries queued, leaf 4 stays PEND with busy[4] = 1; after one pop, leaf 4 is pushed in the same cycle and count stays 4.
REQ-038 Spurious done: leaf_done[2] pulsed while leaf 2 is IDLE -> no FIFO push, cpl_valid remains 0.
REQ-039 Mid-run reset: 3 leaves in RUN and 2 entries queued, pulse rst_n low -> all outputs 0; a later leaf_done[0] pulse is ignored.
